// File: rtl/wb_sci_arbiter.sv
// Round-robin arbiter sharing one Wishbone-to-SCI bridge among up to four masters.
// One transaction outstanding; a watchdog errors out hung SCI cycles and drains the late ack.
module wb_sci_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NUM_MASTERS-1:0]                M_CYC,
  input  logic [NUM_MASTERS-1:0]                M_STB,
  input  logic [NUM_MASTERS-1:0]                M_WE,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     M_ADDR,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     M_WDATA,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] M_SEL,
  output logic [NUM_MASTERS-1:0]                M_STALL,
  output logic [NUM_MASTERS-1:0]                M_ACK,
  output logic [NUM_MASTERS-1:0]                M_ERR,
  output logic [DATA_WIDTH-1:0]                 M_RDATA,
  output logic                                  S_CYC,
  output logic                                  S_STB,
  output logic                                  S_WE,
  output logic [ADDR_WIDTH-1:0]                 S_ADDR,
  output logic [DATA_WIDTH-1:0]                 S_WDATA,
  output logic [DATA_WIDTH/8-1:0]               S_SEL,
  input  logic                                  S_STALL,
  input  logic                                  S_ACK,
  input  logic                                  S_ERR,
  input  logic [DATA_WIDTH-1:0]                 S_RDATA,
  output logic [NUM_MASTERS-1:0]                GRANT,
  output logic                                  TIMEOUT_EVT
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DRAIN} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SEL_W-1:0]      sel;
  } wb_req_t;

  state_t                 state_q, state_d;
  wb_req_t                req_q;
  logic [IDX_W-1:0]       last_grant_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   abandon_q;
  logic [NUM_MASTERS-1:0] ack_q, err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   tmo_q, s_cyc_q, s_stb_q;

  logic [NUM_MASTERS-1:0] req;
  logic [IDX_W-1:0]       cand, win_idx;
  logic                   win_found;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic                   accept, rsp_ack, rsp_err, tmo, deliver;

  logic [ADDR_WIDTH-1:0]  m_addr_a  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  m_wdata_a [NUM_MASTERS];
  logic [SEL_W-1:0]       m_sel_a   [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign m_addr_a[gi]  = M_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wdata_a[gi] = M_WDATA[gi*DATA_WIDTH +: DATA_WIDTH];
    assign m_sel_a[gi]   = M_SEL[gi*SEL_W +: SEL_W];
  end

  assign req = M_CYC & M_STB;

  // Round-robin pick: first requester scanning upward from last_grant+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((32'(last_grant_q) + k) % NUM_MASTERS);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot = NUM_MASTERS'(1) << win_idx;
  assign deliver    = !abandon_q && M_CYC[last_grant_q];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rsp_ack = 1'b0;
    rsp_err = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !RST) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!S_STALL) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Error beats ack when both arrive together.
        if (S_ERR) begin
          rsp_err = 1'b1;
          state_d = ST_IDLE;
        end else if (S_ACK) begin
          rsp_ack = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_err = 1'b1;
          tmo     = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (S_ACK || S_ERR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign M_STALL = ~(win_onehot & {NUM_MASTERS{accept}});

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      abandon_q    <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      tmo_q        <= 1'b0;
      s_cyc_q      <= 1'b0;
      s_stb_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
      if (accept) begin
        req_q.we     <= M_WE[win_idx];
        req_q.addr   <= m_addr_a[win_idx];
        req_q.wdata  <= m_wdata_a[win_idx];
        req_q.sel    <= m_sel_a[win_idx];
        last_grant_q <= win_idx;
        abandon_q    <= 1'b0;
      end else if ((state_q == ST_ISSUE || state_q == ST_WAIT) && !M_CYC[last_grant_q]) begin
        abandon_q <= 1'b1;
      end
      if (accept)                  grant_q <= win_onehot;
      else if (state_d == ST_IDLE) grant_q <= '0;
      ack_q <= (rsp_ack && deliver) ? grant_q : '0;
      err_q <= (rsp_err && deliver) ? grant_q : '0;
      if (rsp_ack && deliver && !req_q.we) rdata_q <= S_RDATA;
      tmo_q   <= tmo;
      s_cyc_q <= (state_d != ST_IDLE);
      s_stb_q <= (state_d == ST_ISSUE);
    end
  end

  assign M_ACK       = ack_q;
  assign M_ERR       = err_q;
  assign M_RDATA     = rdata_q;
  assign S_CYC       = s_cyc_q;
  assign S_STB       = s_stb_q;
  assign S_WE        = req_q.we;
  assign S_ADDR      = req_q.addr;
  assign S_WDATA     = req_q.wdata;
  assign S_SEL       = req_q.sel;
  assign GRANT       = grant_q;
  assign TIMEOUT_EVT = tmo_q;

endmodule
